// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRequest,
    StWaitEdge,
    StShift,
    StAck,
    StWaitIdle
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Defaults assume a 50 MHz system clock.
  localparam int unsigned PS2_INHIBIT_CYCLES     = 6000;
  localparam int unsigned PS2_SETUP_CYCLES       = 50;
  localparam int unsigned PS2_FIRST_EDGE_TIMEOUT = 750000;
  localparam int unsigned PS2_FRAME_TIMEOUT      = 100000;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a falling-edge
// detector on the synchronized clock. Shared with the keyboard receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_meta;
  logic [1:0] dat_meta;
  logic       clk_prev;

  // Sync stages reset to the idle (released, high) bus level so no edge is seen out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta <= 2'b11;
      dat_meta <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_meta <= {clk_meta[0], clk_in};
      dat_meta <= {dat_meta[0], dat_in};
      clk_prev <= clk_meta[1];
    end
  end

  assign clk_sync = clk_meta[1];
  assign dat_sync = dat_meta[1];
  assign clk_fall = clk_prev & ~clk_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter. Inhibits the bus, issues a request to
// send, shifts {stop, parity, data} out LSB first on device clock falling edges
// and checks the device acknowledge. The OE outputs drive open-drain buffers at
// the pad: line = oe ? 1'b0 : 1'bz.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES     = PS2_INHIBIT_CYCLES,
  parameter int unsigned SETUP_CYCLES       = PS2_SETUP_CYCLES,
  parameter int unsigned FIRST_EDGE_TIMEOUT = PS2_FIRST_EDGE_TIMEOUT,
  parameter int unsigned FRAME_TIMEOUT      = PS2_FRAME_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned CntW = $clog2(FIRST_EDGE_TIMEOUT + 1);
  typedef logic [CntW-1:0] cnt_t;

  // Counter loads are N-1 so that a phase spans exactly N cycles.
  localparam cnt_t InhibitLoad = cnt_t'(INHIBIT_CYCLES - 1);
  localparam cnt_t SetupLoad   = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t FirstLoad   = cnt_t'(FIRST_EDGE_TIMEOUT - 1);
  localparam cnt_t FrameLoad   = cnt_t'(FRAME_TIMEOUT - 1);

  ps2_tx_state_e state;
  cnt_t          cnt;
  logic [3:0]    edge_idx;
  logic [9:0]    frame;

  logic clk_sync;
  logic dat_sync;
  logic clk_fall;
  logic cnt_zero;
  logic timed_state;

  ps2_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

  assign cnt_zero    = (cnt == '0);
  assign timed_state = (state == StWaitEdge) || (state == StShift) ||
                       (state == StAck) || (state == StWaitIdle);

  // Transmit FSM with registered bus enables, handshake and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      edge_idx   <= '0;
      frame      <= '0;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      rx_inhibit <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      // A timeout takes priority over an edge arriving in the same cycle.
      if (timed_state && cnt_zero) begin
        state      <= StIdle;
        tx_error   <= 1'b1;
        tx_ready   <= 1'b1;
        rx_inhibit <= 1'b0;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (tx_valid && tx_ready) begin
              frame      <= {1'b1, odd_parity(tx_data), tx_data};
              cnt        <= InhibitLoad;
              edge_idx   <= '0;
              state      <= StInhibit;
              tx_ready   <= 1'b0;
              rx_inhibit <= 1'b1;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
            end
          end
          StInhibit: begin
            if (cnt_zero) begin
              state      <= StRequest;
              cnt        <= SetupLoad;
              ps2_dat_oe <= 1'b1;
            end else begin
              cnt <= cnt - cnt_t'(1);
            end
          end
          StRequest: begin
            if (cnt_zero) begin
              state      <= StWaitEdge;
              cnt        <= FirstLoad;
              ps2_clk_oe <= 1'b0;
            end else begin
              cnt <= cnt - cnt_t'(1);
            end
          end
          StWaitEdge: begin
            if (clk_fall) begin
              ps2_dat_oe <= ~frame[0];
              frame      <= frame >> 1;
              edge_idx   <= 4'd1;
              cnt        <= FrameLoad;
              state      <= StShift;
            end else begin
              cnt <= cnt - cnt_t'(1);
            end
          end
          StShift: begin
            cnt <= cnt - cnt_t'(1);
            if (clk_fall) begin
              ps2_dat_oe <= ~frame[0];
              frame      <= frame >> 1;
              edge_idx   <= edge_idx + 4'd1;
              // Edge 10 puts the stop bit (line released) on the bus.
              if (edge_idx == 4'd9) begin
                state <= StAck;
              end
            end
          end
          StAck: begin
            cnt <= cnt - cnt_t'(1);
            if (clk_fall) begin
              edge_idx <= 4'd11;
              if (!dat_sync) begin
                state <= StWaitIdle;
              end else begin
                state      <= StIdle;
                tx_error   <= 1'b1;
                tx_ready   <= 1'b1;
                rx_inhibit <= 1'b0;
              end
            end
          end
          StWaitIdle: begin
            if (clk_sync && dat_sync) begin
              state      <= StIdle;
              tx_done    <= 1'b1;
              tx_ready   <= 1'b1;
              rx_inhibit <= 1'b0;
            end else begin
              cnt <= cnt - cnt_t'(1);
            end
          end
          default: begin
            state      <= StIdle;
            tx_ready   <= 1'b1;
            rx_inhibit <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned TI = 60;
  localparam int unsigned TS = 5;
  localparam int unsigned TF = 3000;
  localparam int unsigned TFR = 2000;
  localparam int H = 10;          // device clock half period in system clocks
  localparam int BOUND = 8000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_dat_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_in, ps2_dat_in;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int pulse_bad = 0;
  int b2b_cnt = 0;
  logic prev_done = 1'b0;
  logic rst_clk_oe, rst_dat_oe, pre_rst_dat_oe;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES     (TI),
    .SETUP_CYCLES       (TS),
    .FIRST_EDGE_TIMEOUT (TF),
    .FRAME_TIMEOUT      (TFR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts pulses, flags illegal combinations and back-to-back starts.
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if ((tx_done || tx_error) && (!tx_ready || (tx_done && tx_error))) pulse_bad <= pulse_bad + 1;
    if (prev_done && ps2_clk_oe) b2b_cnt <= b2b_cnt + 1;
    prev_done <= tx_done;
  end

  // Expected line levels: start, data LSB first, odd parity, released stop.
  function automatic logic [10:0] exp_wire(input logic [7:0] b);
    int ones = 0;
    logic [10:0] w;
    w[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w[i+1] = b[i];
      if (b[i]) ones++;
    end
    w[9] = (ones % 2 == 0);
    w[10] = 1'b1;
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < BOUND; i++) begin
      if (tx_ready === 1'b1) return;
      @(negedge clk);
    end
    total++; bad++;
    $display("FAIL wait_idle got=tx_ready %b want=1 within %0d cycles", tx_ready, BOUND);
  endtask

  // Follows the host from acceptance until it releases the clock line.
  task automatic wait_release(output int low_cycles, output int dat_rise, output bit dat_held,
                              output bit ok);
    low_cycles = 0; dat_rise = -1; dat_held = 1'b1; ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe) begin
        ok = 1'b1;
        if (!ps2_dat_oe) dat_held = 1'b0;
        return;
      end
      low_cycles++;
      if (ps2_dat_oe && dat_rise < 0) dat_rise = i;
      if (dat_rise >= 0 && !ps2_dat_oe) dat_held = 1'b0;
    end
  endtask

  // Keyboard model: clocks 11 pulses, samples the line late in each low phase.
  task automatic dev_frame(input int delay, input bit ack_low, input int reset_edge,
                           output logic [10:0] bits, output logic lat_old, output logic lat_new);
    bits = '0; lat_old = 1'b0; lat_new = 1'b0;
    repeat (delay) @(negedge clk);
    bits[0] = ps2_dat_in;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      for (int c = 1; c <= H; c++) begin
        @(negedge clk);
        if (k == 1 && c == 2) lat_old = ps2_dat_oe;
        if (k == 1 && c == 3) lat_new = ps2_dat_oe;
        if (k == reset_edge && c == 6) begin
          pre_rst_dat_oe = ps2_dat_oe;
          #2 reset = 1'b1;
          #1 rst_clk_oe = ps2_clk_oe;
          rst_dat_oe = ps2_dat_oe;
          dev_clk_low = 1'b0;
          dev_dat_low = 1'b0;
          return;
        end
      end
      if (k <= 10) bits[k] = ps2_dat_in;
      dev_clk_low = 1'b0;
      for (int c = 1; c <= H; c++) begin
        @(negedge clk);
        if (k == 11 && c == 2) dev_dat_low = 1'b0;
        if (k == 10 && c == H / 2) dev_dat_low = ack_low;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", tx_done); end
    total++; if (tx_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", tx_error); end
    total++; if (rx_inhibit !== 1'b0) begin bad++; $display("FAIL reset_inhibit got=%b want=0", rx_inhibit); end
    total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b want=0", ps2_clk_oe); end
    total++; if (ps2_dat_oe !== 1'b0) begin bad++; $display("FAIL reset_dat_oe got=%b want=0", ps2_dat_oe); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_request_timing();
    int lc, dr; bit held, ok;
    logic [10:0] bits; logic lo, ln;
    logic [7:0] b = 8'($urandom);
    wait_idle();
    send_byte(b);
    total++; if ({tx_ready, rx_inhibit, ps2_clk_oe} !== 3'b011) begin
      bad++; $display("FAIL start_flags got=%b want=011", {tx_ready, rx_inhibit, ps2_clk_oe});
    end
    wait_release(lc, dr, held, ok);
    total++; if (!ok || lc != int'(TI + TS)) begin
      bad++; $display("FAIL clk_low_cycles got=%0d want=%0d", lc, TI + TS);
    end
    total++; if (dr != int'(TI)) begin bad++; $display("FAIL dat_rise got=%0d want=%0d", dr, TI); end
    total++; if (!held) begin bad++; $display("FAIL dat_held got=0 want=1"); end
    dev_frame(30, 1'b1, 0, bits, lo, ln);
    total++; if (bits !== exp_wire(b)) begin
      bad++; $display("FAIL timing_frame got=%b want=%b", bits, exp_wire(b));
    end
  endtask

  task automatic test_normal();
    int lc, dr; bit held, ok;
    logic [10:0] bits; logic lo, ln; int d0, e0;
    logic [7:0] b;
    for (int n = 0; n < 5; n++) begin
      b = (n == 0) ? PS2_CMD_SET_LEDS : 8'($urandom);
      wait_idle();
      d0 = done_cnt; e0 = err_cnt;
      send_byte(b);
      wait_release(lc, dr, held, ok);
      dev_frame(int'($urandom_range(5, 200)), 1'b1, 0, bits, lo, ln);
      repeat (2) @(negedge clk);
      total++; if (bits !== exp_wire(b)) begin
        bad++; $display("FAIL frame_%0h got=%b want=%b", b, bits, exp_wire(b));
      end
      total++; if ({lo, ln} !== {1'b1, ~b[0]}) begin
        bad++; $display("FAIL latency_%0h got=%b want=%b", b, {lo, ln}, {1'b1, ~b[0]});
      end
      total++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
        bad++; $display("FAIL pulses_%0h got=done %0d err %0d want=1 0", b, done_cnt - d0,
                        err_cnt - e0);
      end
      total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL ready_after got=%b want=1", tx_ready); end
    end
  endtask

  task automatic test_parity();
    logic [7:0] pb [3];
    logic pp [3];
    int lc, dr; bit held, ok;
    logic [10:0] bits; logic lo, ln;
    pb[0] = 8'h01; pb[1] = 8'h00; pb[2] = 8'hFF;
    pp[0] = 1'b0; pp[1] = 1'b1; pp[2] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_idle();
      send_byte(pb[n]);
      wait_release(lc, dr, held, ok);
      dev_frame(20, 1'b1, 0, bits, lo, ln);
      total++; if (bits[9] !== pp[n]) begin
        bad++; $display("FAIL parity_%0h got=%b want=%b", pb[n], bits[9], pp[n]);
      end
    end
  endtask

  task automatic test_no_clock();
    int lc, dr; bit held, ok; int k; int d0;
    wait_idle();
    d0 = done_cnt;
    send_byte(PS2_CMD_RESET);
    wait_release(lc, dr, held, ok);
    k = 0;
    while (tx_error !== 1'b1 && k < int'(TF) + 100) begin
      @(negedge clk);
      k++;
    end
    total++; if (k != int'(TF)) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", k, TF); end
    total++; if ({ps2_clk_oe, ps2_dat_oe, tx_ready} !== 3'b001) begin
      bad++; $display("FAIL timeout_state got=%b want=001", {ps2_clk_oe, ps2_dat_oe, tx_ready});
    end
    @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL timeout_done got=%0d want=0", done_cnt - d0); end
  endtask

  task automatic test_missing_ack();
    int lc, dr; bit held, ok;
    logic [10:0] bits; logic lo, ln; int d0, e0;
    wait_idle();
    d0 = done_cnt; e0 = err_cnt;
    send_byte(PS2_CMD_ENABLE);
    wait_release(lc, dr, held, ok);
    dev_frame(40, 1'b0, 0, bits, lo, ln);
    repeat (2) @(negedge clk);
    total++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      bad++; $display("FAIL noack_pulses got=err %0d done %0d want=1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int lc, dr; bit held, ok;
    logic [10:0] bits; logic lo, ln; int d0, e0;
    wait_idle();
    d0 = done_cnt; e0 = err_cnt;
    send_byte(PS2_CMD_SET_LEDS);
    wait_release(lc, dr, held, ok);
    dev_frame(25, 1'b1, 5, bits, lo, ln);
    total++; if (pre_rst_dat_oe !== 1'b1) begin
      bad++; $display("FAIL bit4_drive got=%b want=1", pre_rst_dat_oe);
    end
    total++; if ({rst_clk_oe, rst_dat_oe} !== 2'b00) begin
      bad++; $display("FAIL reset_release got=%b want=00", {rst_clk_oe, rst_dat_oe});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (done_cnt != d0 || err_cnt != e0) begin
      bad++; $display("FAIL reset_pulses got=done %0d err %0d want=0 0", done_cnt - d0, err_cnt - e0);
    end
    d0 = done_cnt;
    send_byte(PS2_CMD_ENABLE);
    wait_release(lc, dr, held, ok);
    dev_frame(30, 1'b1, 0, bits, lo, ln);
    repeat (2) @(negedge clk);
    total++; if (bits !== exp_wire(PS2_CMD_ENABLE) || done_cnt - d0 != 1) begin
      bad++; $display("FAIL after_reset got=%b done %0d want=%b done 1", bits, done_cnt - d0,
                      exp_wire(PS2_CMD_ENABLE));
    end
  endtask

  task automatic test_back_to_back();
    int lc, dr; bit held, ok;
    logic [10:0] bits; logic lo, ln; int d0, e0, b0;
    wait_idle();
    d0 = done_cnt; e0 = err_cnt; b0 = b2b_cnt;
    @(negedge clk);
    tx_data = PS2_CMD_SET_LEDS;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = PS2_CMD_RESET;
    wait_release(lc, dr, held, ok);
    dev_frame(30, 1'b1, 0, bits, lo, ln);
    tx_valid = 1'b0;
    total++; if (bits !== exp_wire(PS2_CMD_SET_LEDS)) begin
      bad++; $display("FAIL busy_first got=%b want=%b", bits, exp_wire(PS2_CMD_SET_LEDS));
    end
    wait_release(lc, dr, held, ok);
    dev_frame(30, 1'b1, 0, bits, lo, ln);
    repeat (2) @(negedge clk);
    total++; if (bits !== exp_wire(PS2_CMD_RESET)) begin
      bad++; $display("FAIL busy_second got=%b want=%b", bits, exp_wire(PS2_CMD_RESET));
    end
    total++; if (done_cnt - d0 != 2 || err_cnt != e0 || b2b_cnt - b0 != 1) begin
      bad++; $display("FAIL b2b got=done %0d err %0d b2b %0d want=2 0 1", done_cnt - d0,
                      err_cnt - e0, b2b_cnt - b0);
    end
  endtask

  task automatic test_pulses();
    total++; if (pulse_bad != 0) begin bad++; $display("FAIL pulse_rules got=%0d want=0", pulse_bad); end
  endtask

  initial begin
    test_reset();
    test_request_timing();
    test_normal();
    test_parity();
    test_no_clock();
    test_missing_ack();
    test_reset_mid();
    test_back_to_back();
    test_pulses();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
